// File: rtl/twf_pkg.sv
// Shared constants and types for the twiddle-apply stage.
package twf_pkg;
  localparam int LANES   = 16;
  localparam int NGRP    = 32;
  localparam int TW_W    = 10;
  localparam int TW_FRAC = 8;
  localparam int GRP_W   = 5;

  typedef logic signed [TW_W-1:0] tw_t;
  typedef logic [GRP_W-1:0]       grp_t;
endpackage

// File: rtl/twf_apply_seq_cmul.sv
// One lane of the twiddle multiply: full-width complex product, round half-up
// by TW_FRAC bits, saturate to OW.
module twf_cmul
  import twf_pkg::*;
#(
  parameter int DW   = 12,
  parameter int OW   = 12,
  parameter int TW_W = twf_pkg::TW_W,
  parameter int FRAC = TW_FRAC
) (
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  input  logic signed [TW_W-1:0] c,
  input  logic signed [TW_W-1:0] d,
  output logic signed [OW-1:0]   pr,
  output logic signed [OW-1:0]   pi
);
  localparam int PW = DW + TW_W + 1;
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (FRAC - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (OW - 1) - 1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;

  logic signed [PW-1:0] ax, bx, cx, dx;
  logic signed [PW-1:0] re_full, im_full, re_rnd, im_rnd;

  function automatic logic signed [OW-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV)      return MAXV[OW-1:0];
    else if (v < MINV) return MINV[OW-1:0];
    else               return v[OW-1:0];
  endfunction

  always_comb begin
    ax      = {{(PW-DW){a[DW-1]}}, a};
    bx      = {{(PW-DW){b[DW-1]}}, b};
    cx      = {{(PW-TW_W){c[TW_W-1]}}, c};
    dx      = {{(PW-TW_W){d[TW_W-1]}}, d};
    re_full = ax * cx - bx * dx;
    im_full = ax * dx + bx * cx;
    re_rnd  = (re_full + RND) >>> FRAC;
    im_rnd  = (im_full + RND) >>> FRAC;
    pr      = sat(re_rnd);
    pi      = sat(im_rnd);
  end
endmodule

// File: rtl/twf_apply_seq.sv
// Twiddle-apply stage: sequences 32 groups per frame against a registered ROM
// and multiplies 16 lanes per beat. Optional IFFT conjugation: TWF_CONJ_EN.
module twf_apply_seq
  import twf_pkg::*;
#(
  parameter int DW   = 12,
  parameter int OW   = 12,
  parameter int TW_W = twf_pkg::TW_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0][DW-1:0]   in_re,
  input  logic [LANES-1:0][DW-1:0]   in_im,
  output grp_t                       grp_idx,
  input  logic [LANES-1:0][TW_W-1:0] tw_re,
  input  logic [LANES-1:0][TW_W-1:0] tw_im,
`ifdef TWF_CONJ_EN
  input  logic                       inv,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0][OW-1:0]   out_re,
  output logic [LANES-1:0][OW-1:0]   out_im,
  output logic                       out_last,
  output grp_t                       out_grp
);
  logic                       s1_valid, s1_last, s1_adv, s2_adv, accept;
  logic [LANES-1:0][DW-1:0]   s1_re, s1_im;
  grp_t                       s1_grp, g_cnt;
  logic [LANES-1:0][OW-1:0]   prod_re, prod_im;
  logic [LANES-1:0][TW_W-1:0] tw_im_eff;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;
  // Hold the ROM address while S1 is stalled so its registered output keeps
  // matching the beat sitting in S1.
  assign grp_idx  = (s1_valid && !s1_adv) ? s1_grp : g_cnt;

`ifdef TWF_CONJ_EN
  logic inv_frame, s1_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_frame <= 1'b0;
      s1_inv    <= 1'b0;
    end else if (clear) begin
      inv_frame <= 1'b0;
      s1_inv    <= 1'b0;
    end else if (accept) begin
      if (g_cnt == '0) inv_frame <= inv;
      s1_inv <= (g_cnt == '0) ? inv : inv_frame;
    end
  end

  always_comb begin
    tw_im_eff = tw_im;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (s1_inv) begin
        if (tw_im[l] == {1'b1, {(TW_W-1){1'b0}}})
          tw_im_eff[l] = {1'b0, {(TW_W-1){1'b1}}};
        else
          tw_im_eff[l] = -tw_im[l];
      end
    end
  end
`else
  assign tw_im_eff = tw_im;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    twf_cmul #(
      .DW  (DW),
      .OW  (OW),
      .TW_W(TW_W),
      .FRAC(TW_FRAC)
    ) u_cmul (
      .a (s1_re[l]),
      .b (s1_im[l]),
      .c (tw_re[l]),
      .d (tw_im_eff[l]),
      .pr(prod_re[l]),
      .pi(prod_im[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_cnt    <= '0;
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_grp   <= '0;
      s1_last  <= 1'b0;
    end else if (clear) begin
      g_cnt    <= '0;
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_grp   <= '0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      g_cnt    <= g_cnt + grp_t'(1);
      s1_valid <= 1'b1;
      s1_re    <= in_re;
      s1_im    <= in_im;
      s1_grp   <= g_cnt;
      s1_last  <= (g_cnt == grp_t'(NGRP - 1));
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_grp   <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_grp   <= '0;
      out_last  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_re   <= prod_re;
        out_im   <= prod_im;
        out_grp  <= s1_grp;
        out_last <= s1_last;
      end
    end
  end
endmodule

// File: tb/tb_twf_apply_seq.sv
// Directed bench for twf_apply_seq with a registered twiddle-ROM model.
module tb_twf_apply_seq;
  import twf_pkg::*;

  localparam int DW  = 12;
  localparam int OW  = 12;
  localparam int TWW = 10;

  logic clk, rst, clear, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [LANES-1:0][DW-1:0]  in_re, in_im;
  logic [LANES-1:0][TWW-1:0] tw_re, tw_im;
  logic [LANES-1:0][OW-1:0]  out_re, out_im;
  grp_t grp_idx, out_grp;
`ifdef TWF_CONJ_EN
  logic inv;
`endif

  int rom_re [NGRP];
  int rom_im [NGRP];
  int checks = 0;
  int errors = 0;

  twf_apply_seq #(.DW(DW), .OW(OW), .TW_W(TWW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .grp_idx(grp_idx), .tw_re(tw_re), .tw_im(tw_im),
`ifdef TWF_CONJ_EN
    .inv(inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .out_grp(out_grp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      tw_re[l] <= TWW'(rom_re[grp_idx]);
      tw_im[l] <= TWW'(rom_im[grp_idx]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic set_rom(input int r, input int i);
    for (int g = 0; g < NGRP; g++) begin
      rom_re[g] = r;
      rom_im[g] = i;
    end
  endtask

  task automatic drive_lanes(input int r, input int i);
    for (int l = 0; l < LANES; l++) begin
      in_re[l] = DW'(r);
      in_im[l] = DW'(i);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
  endtask

  // Sends one beat with all lanes equal and returns lane 0 of the resulting output.
  task automatic run_beat(input int r, input int i, output int ore, output int oim,
                          output int ogrp, output int olast, output int lat, output bit same);
    @(negedge clk);
    drive_lanes(r, i);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    for (int c = 0; c < 10 && !in_ready; c++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    ore   = int'($signed(out_re[0]));
    oim   = int'($signed(out_im[0]));
    ogrp  = int'(out_grp);
    olast = int'(out_last);
    same  = 1'b1;
    for (int l = 1; l < LANES; l++)
      if (out_re[l] !== out_re[0] || out_im[l] !== out_im[0]) same = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_lanes(0, 0);
`ifdef TWF_CONJ_EN
    inv = 1'b0;
`endif
    set_rom(256, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || grp_idx !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b grp_idx=%0d, expected 0 1 0",
               out_valid, in_ready, grp_idx);
    end
    drive_lanes(5, 5);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_hs: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    checks++;
    if (grp_idx !== 5'd0 || out_grp !== 5'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_grp: grp_idx=%0d out_grp=%0d out_last=%b, expected 0 0 0",
               grp_idx, out_grp, out_last);
    end
    checks++;
    if (out_re !== '0 || out_im !== '0) begin
      errors++;
      $display("FAIL midreset_data: out_re[0]=%0d out_im[0]=%0d, expected 0 0",
               $signed(out_re[0]), $signed(out_im[0]));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
  endtask

  task automatic test_identity();
    int ore, oim, ogrp, olast, lat;
    bit same;
    set_rom(256, 0);
    run_beat(100, -37, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL identity_latency: got %0d edges, expected 2", lat);
    end
    checks++;
    if (ore !== 100 || oim !== -37 || !same) begin
      errors++;
      $display("FAIL identity_data: got (%0d,%0d) same=%b, expected (100,-37) same=1", ore, oim, same);
    end
    checks++;
    if (ogrp !== 0 || olast !== 0) begin
      errors++;
      $display("FAIL identity_grp: got grp %0d last %0d, expected grp 0 last 0", ogrp, olast);
    end
  endtask

  task automatic test_mul_j();
    int ore, oim, ogrp, olast, lat;
    bit same;
    set_rom(0, 256);
    run_beat(100, -37, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== 37 || oim !== 100 || !same) begin
      errors++;
      $display("FAIL mul_j: got (%0d,%0d) same=%b, expected (37,100) same=1", ore, oim, same);
    end
    checks++;
    if (ogrp !== 1) begin
      errors++;
      $display("FAIL mul_j_grp: got %0d, expected 1", ogrp);
    end
  endtask

  task automatic test_round_sat();
    int ore, oim, ogrp, olast, lat;
    bit same;
    set_rom(128, 0);
    run_beat(3, 0, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== 2 || oim !== 0) begin
      errors++;
      $display("FAIL round_pos: got (%0d,%0d), expected (2,0)", ore, oim);
    end
    run_beat(-3, 0, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== -1 || oim !== 0) begin
      errors++;
      $display("FAIL round_neg: got (%0d,%0d), expected (-1,0)", ore, oim);
    end
    set_rom(256, 256);
    run_beat(2047, 2047, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== 0 || oim !== 2047) begin
      errors++;
      $display("FAIL sat_pos: got (%0d,%0d), expected (0,2047)", ore, oim);
    end
    run_beat(-2048, -2048, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== 0 || oim !== -2048) begin
      errors++;
      $display("FAIL sat_neg: got (%0d,%0d), expected (0,-2048)", ore, oim);
    end
  endtask

  task automatic test_clear();
    int ore, oim, ogrp, olast, lat;
    bit same;
    set_rom(256, 0);
    @(negedge clk);
    drive_lanes(9, 9);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || grp_idx !== 5'd0) begin
      errors++;
      $display("FAIL clear_state: out_valid=%b in_ready=%b grp_idx=%0d, expected 0 1 0",
               out_valid, in_ready, grp_idx);
    end
    run_beat(-50, 20, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ogrp !== 0 || ore !== -50 || oim !== 20) begin
      errors++;
      $display("FAIL clear_next: got grp %0d (%0d,%0d), expected grp 0 (-50,20)", ogrp, ore, oim);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, k, er, ei, bad_lane;
    bit bad;
    bit seen_extra;
    pulse_clear();
    for (int g = 0; g < NGRP; g++) begin
      rom_re[g] = (g % 2 == 0) ? 256 : 0;
      rom_im[g] = (g % 2 == 0) ? 0 : 256;
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (cyc < 400 && got < 64) begin
      @(negedge clk);
      out_ready = !(cyc == 4 || cyc == 9 || cyc == 10 || cyc == 20 || cyc == 37);
      in_valid  = (sent < 64);
      for (int l = 0; l < LANES; l++) begin
        in_re[l] = DW'(sent * 8 + l);
        in_im[l] = DW'(-sent - 1);
      end
      #1;
      if (!in_ready) begin
        checks++;
        if (grp_idx !== grp_t'((sent - 1) % 32)) begin
          errors++;
          $display("FAIL stall_grp_idx: got %0d, expected %0d", grp_idx, (sent - 1) % 32);
        end
      end
      if (out_valid && out_ready) begin
        k = got;
        bad = 1'b0;
        bad_lane = 0;
        for (int l = 0; l < LANES; l++) begin
          er = (k % 2 == 0) ? k * 8 + l : k + 1;
          ei = (k % 2 == 0) ? -k - 1 : k * 8 + l;
          if (!bad && (int'($signed(out_re[l])) !== er || int'($signed(out_im[l])) !== ei)) begin
            bad = 1'b1;
            bad_lane = l;
          end
        end
        checks++;
        if (bad) begin
          errors++;
          er = (k % 2 == 0) ? k * 8 + bad_lane : k + 1;
          ei = (k % 2 == 0) ? -k - 1 : k * 8 + bad_lane;
          $display("FAIL b2b_data beat %0d lane %0d: got (%0d,%0d), expected (%0d,%0d)", k, bad_lane,
                   $signed(out_re[bad_lane]), $signed(out_im[bad_lane]), er, ei);
        end
        checks++;
        if (out_grp !== grp_t'(k % 32) || out_last !== (k % 32 == 31)) begin
          errors++;
          $display("FAIL b2b_grp beat %0d: got grp %0d last %b, expected grp %0d last %b",
                   k, out_grp, out_last, k % 32, (k % 32 == 31));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    checks++;
    if (got !== 64 || sent !== 64) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs from %0d inputs, expected 64 and 64", got, sent);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen_extra = 1'b0;
    repeat (5) begin
      #1;
      if (out_valid) seen_extra = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_extra) begin
      errors++;
      $display("FAIL b2b_extra: out_valid=1 after last beat, expected 0");
    end
  endtask

`ifdef TWF_CONJ_EN
  task automatic test_conj();
    int ore, oim, ogrp, olast, lat;
    bit same;
    pulse_clear();
    set_rom(0, 256);
    inv = 1'b1;
    run_beat(100, -37, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== -37 || oim !== -100) begin
      errors++;
      $display("FAIL conj_g0: got (%0d,%0d), expected (-37,-100)", ore, oim);
    end
    inv = 1'b0;
    run_beat(100, -37, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== -37 || oim !== -100 || ogrp !== 1) begin
      errors++;
      $display("FAIL conj_hold: got grp %0d (%0d,%0d), expected grp 1 (-37,-100)", ogrp, ore, oim);
    end
    pulse_clear();
    run_beat(100, -37, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== 37 || oim !== 100) begin
      errors++;
      $display("FAIL conj_off: got (%0d,%0d), expected (37,100)", ore, oim);
    end
    pulse_clear();
    set_rom(0, -512);
    inv = 1'b1;
    run_beat(100, 0, ore, oim, ogrp, olast, lat, same);
    checks++;
    if (ore !== 0 || oim !== 200) begin
      errors++;
      $display("FAIL conj_negsat: got (%0d,%0d), expected (0,200)", ore, oim);
    end
    inv = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_mul_j();
    test_round_sat();
    test_clear();
    test_back_to_back();
`ifdef TWF_CONJ_EN
    test_conj();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
